// File: rtl/avg_pkg.sv
// Shared types and constants for the averaging sample loader.
// Used by avg_shift_window and avg_sample_loader.
package avg_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int NUM_SAMPLES   = 8;
    localparam int CNT_W         = 3;
    localparam int DEF_DATAWIDTH = 16;

endpackage

// File: rtl/avg_shift_window.sv
// Parameterised shift register, all taps visible.
// taps[0] is the oldest entry, taps[DEPTH-1] the newest.
module avg_shift_window
    import avg_pkg::*;
#(
    parameter int W     = DEF_DATAWIDTH,
    parameter int DEPTH = NUM_SAMPLES
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      en,
    input  logic [W-1:0]              din,
    output logic [DEPTH-1:0][W-1:0]   taps
);

    // shift towards the oldest slot; clear has priority
    always_ff @(posedge clk) begin
        if (clr) begin
            taps <= '0;
        end else if (en) begin
            taps <= {din, taps[DEPTH-1:1]};
        end
    end

endmodule

// File: rtl/avg_sample_loader.sv
// Serial-to-parallel window loader feeding the 8-input averager.
// Optional macro AVG_LOADER_SLIDING_EN selects sliding-window mode.
module avg_sample_loader
    import avg_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int SHIFT_AMT = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 frame_ack,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] e,
    output logic [DATAWIDTH-1:0] f,
    output logic [DATAWIDTH-1:0] g,
    output logic [DATAWIDTH-1:0] h,
    output logic [7:0]           sa,
    output logic                 frame_valid,
    output logic [7:0]           frame_cnt
);

    state_t                                state;
    state_t                                state_nxt;
    logic [CNT_W-1:0]                      cnt;
    logic [CNT_W-1:0]                      cnt_nxt;
    logic                                  fv_nxt;
    logic [7:0]                            fcnt_nxt;
    logic                                  acc;
    logic [NUM_SAMPLES-1:0][DATAWIDTH-1:0] taps;

    assign acc = in_valid & in_ready;
    assign sa  = 8'(SHIFT_AMT);

`ifdef AVG_LOADER_SLIDING_EN
    logic unused_ack;
    assign unused_ack = frame_ack;
`endif

    // state, fill count and frame status registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= FILL;
            cnt         <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            frame_valid <= fv_nxt;
            frame_cnt   <= fcnt_nxt;
        end
    end

    // next-state: count accepts, close a frame on the 8th
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fcnt_nxt  = frame_cnt;
`ifdef AVG_LOADER_SLIDING_EN
        fv_nxt    = 1'b0;
`else
        fv_nxt    = frame_valid;
`endif
        unique case (state)
            FILL: begin
                if (acc) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_SAMPLES - 1)) begin
                        state_nxt = HOLD;
                        fv_nxt    = 1'b1;
                        fcnt_nxt  = frame_cnt + 8'd1;
                    end
                end
            end
            HOLD: begin
`ifdef AVG_LOADER_SLIDING_EN
                if (acc) begin
                    fv_nxt   = 1'b1;
                    fcnt_nxt = frame_cnt + 8'd1;
                end
`else
                if (frame_ack) begin
                    state_nxt = FILL;
                    fv_nxt    = 1'b0;
                end
`endif
            end
            default: state_nxt = FILL;
        endcase
    end

    // handshake output: never ready during reset
    always_comb begin
        in_ready = 1'b0;
        if (!Rst) begin
`ifdef AVG_LOADER_SLIDING_EN
            in_ready = 1'b1;
`else
            in_ready = (state == FILL);
`endif
        end
    end

    avg_shift_window #(
        .W     (DATAWIDTH),
        .DEPTH (NUM_SAMPLES)
    ) u_win (
        .clk  (Clk),
        .clr  (Rst),
        .en   (acc),
        .din  (in_data),
        .taps (taps)
    );

    assign a = taps[0];
    assign b = taps[1];
    assign c = taps[2];
    assign d = taps[3];
    assign e = taps[4];
    assign f = taps[5];
    assign g = taps[6];
    assign h = taps[7];

endmodule

// File: doc/avg_sample_loader.md
Name: avg_sample_loader

Overview:
Upstream feeder for the 8-input averaging datapath.
- Accepts a serial stream of samples over a valid/ready handshake and assembles them into an 8-entry window.
- Presents the window in parallel on a..h together with a constant shift amount sa.
- Signals frame_valid when a complete window is stable for the averager, and holds it until the consumer acknowledges.

Parameters:
- DATAWIDTH, 16: width of each sample and of outputs a..h.
- SHIFT_AMT, 1: constant driven on sa. Three cascaded shifts by 1 give divide-by-8.

Ports:
- Clk, input, 1: clock. All logic rising-edge.
- Rst, input, 1: synchronous active-high reset.
- in_data, input, DATAWIDTH: incoming sample.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: loader can accept a sample this cycle.
- frame_ack, input, 1: consumer has captured the current window.
- a, b, c, d, e, f, g, h, output, DATAWIDTH each: window slots; a is the oldest sample, h the newest.
- sa, output, 8: shift amount, equal to SHIFT_AMT, zero-extended or truncated to 8 bits.
- frame_valid, output, 1: a..h hold a complete window.
- frame_cnt, output, 8: number of frames completed, modulo 256.

Behaviour:
- States: FILL, HOLD. State is held in a registered enum.
- Reset (Rst=1 at clock edge):
  - state=FILL, fill count=0.
  - a..h=0, frame_valid=0, frame_cnt=0.
  - in_ready is forced 0 while Rst=1, regardless of state.
- Accept condition: in_valid & in_ready. A sample is accepted only on an edge where this is true.
- On accept: window shifts as a<=b, b<=c, ..., g<=h, h<=in_data; count increments.
- FILL:
  - in_ready=1.
  - On the 8th accept (count==7): count<=0, state<=HOLD, frame_valid<=1, frame_cnt<=frame_cnt+1 (wraps 255->0).
  - frame_valid becomes 1 on the same edge that loads h.
- HOLD:
  - in_ready=0; a..h frozen; frame_valid=1.
  - frame_ack=1 -> state<=FILL, frame_valid<=0.
  - frame_ack in FILL is ignored.
- Latency: the first sample is visible on h one cycle after its accept. The window is complete one cycle after the 8th accept.
- in_valid with in_ready=0: no shift. Upstream must hold its data.
- frame_ack together with in_valid in HOLD: the sample is not accepted that cycle. It is accepted no earlier than the following cycle, in FILL.
- The window is not cleared between frames. After ack, the old values shift out as new samples arrive.
- Reset mid-fill or mid-hold: partial window discarded, all outputs return to reset values.
- sa is combinational constant; unaffected by reset.
- No arithmetic beyond the 3-bit count (wraps 7->0) and the 8-bit frame_cnt.

Optional Feature:
- Macro: AVG_LOADER_SLIDING_EN.
- Defined:
  - After the first 8 accepts the block enters HOLD permanently (until reset).
  - In HOLD: in_ready=1 (except during Rst); frame_ack is ignored.
  - Each accept shifts the window; frame_valid is a one-cycle pulse on the edge following every accept, starting from the 8th.
  - frame_cnt increments on every such pulse.
- Not defined: block mode exactly as described above.

Decomposition:
- Shared package avg_pkg contains:
  - state enum {FILL, HOLD};
  - NUM_SAMPLES=8;
  - CNT_W=3;
  - default DATAWIDTH=16.
- One sub-module, avg_shift_window: 8-deep parameterised shift register with enable and synchronous clear, exposing all taps.
- FSM, counters and handshake live in the top.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles -> a..h=0, frame_valid=0, frame_cnt=0, in_ready=0. The cycle after release -> in_ready=1.
- Block fill: feed 1,2,...,8 back-to-back -> after the 8th accept: a=1, h=8, frame_valid=1, in_ready=0, frame_cnt=1. Values stay frozen for 5 cycles without ack.
- Gapped input and backpressure:
  - 8 samples with in_valid toggling -> only accepted samples shift in.
  - In HOLD, in_valid=1 with 0xAAAA -> window unchanged.
  - frame_ack -> frame_valid=0 next cycle; the next sample 9 lands in h.
- Mid-fill reset: accept 5 samples, assert Rst -> all slots 0. Then 8 more samples -> frame formed only after 8 fresh accepts.
- frame_cnt wrap: 256 complete frames -> frame_cnt returns to 0 and frame_valid still behaves normally.
- With AVG_LOADER_SLIDING_EN:
  - Feed 1..10 -> frame_valid pulses 3 times.
  - Final window a=3..h=10.
  - frame_cnt=3; in_ready stays 1 throughout.
